imm_ext_pipe: RTL and testbench

Pipelined, parametrised immediate-extension unit for the datapath decode stage. It widens a DI_W-bit immediate to DO_W bits in one of four modes: zero-extend, sign-extend, upper-load and branch-offset. It is the successor to the plain combinational 16→32 sign/zero extender. Results are registered and travel over a valid/ready handshake, so the unit sits between instruction decode and the execute-stage operand mux without adding a combinational path across the boundary.

---
 rtl/imm_ext_pipe.sv | 154 +++++++++++++++
 tb/tb_imm_ext_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: widens a DI_W-bit immediate to DO_W bits (zero / sign / upper-load / branch-offset).
// Latency: 1 cycle from input transfer to out_valid; sustains 1 word per cycle while out_ready=1.
// Backpressure: IMM_EXT_SKID_EN -> main + skid register, registered in_ready, absorbs 2 words;
//               default build -> single register, in_ready = !out_valid || out_ready.
//
// Build macro: IMM_EXT_SKID_EN (undefined by default).
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   in_valid/in_ready         input handshake
//   in_data[DI_W], in_mode[2] raw immediate and mode (00 zero, 01 sign, 10 upper, 11 branch)
//   out_valid/out_ready       output handshake
//   out_data[DO_W], out_mode  extended result and the mode that produced it
module imm_ext_pipe #(
  parameter int DI_W = 16,
  parameter int DO_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DI_W-1:0] in_data,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DO_W-1:0] out_data,
  output logic [1:0]      out_mode
);

  localparam int PAD_W = DO_W - DI_W;

  logic [DO_W-1:0] sx_dat;
  logic [DO_W-1:0] ext_dat;
  logic            in_xfer;
  logic            out_xfer;
  logic [DO_W-1:0] main_dat;
  logic [1:0]      main_mode;

  // Extension is done before the register, so stored words are already final.
  always_comb begin
    sx_dat = {{PAD_W{in_data[DI_W-1]}}, in_data};
    case (in_mode)
      2'b00:   ext_dat = {{PAD_W{1'b0}}, in_data};
      2'b01:   ext_dat = sx_dat;
      2'b10:   ext_dat = {in_data, {PAD_W{1'b0}}};
      // DO_W >= DI_W+2, so dropping the top two sign copies loses nothing.
      default: ext_dat = {sx_dat[DO_W-3:0], 2'b00};
    endcase
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign out_data = main_dat;
  assign out_mode = main_mode;

`ifdef IMM_EXT_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            ld_main;
  logic            ld_skid;
  logic            main_from_skid;
  logic            in_ready_q;
  logic [DO_W-1:0] skid_dat;
  logic [1:0]      skid_mode;

  always_comb begin
    state_d        = state_q;
    ld_main        = 1'b0;
    ld_skid        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          ld_main = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          state_d = TWO;
          ld_skid = 1'b1;
        end else if (in_xfer && out_xfer) begin
          ld_main = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so no input can arrive alongside the drain.
        if (out_xfer) begin
          state_d        = ONE;
          ld_main        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_dat   <= '0;
      main_mode  <= 2'b00;
      skid_dat   <= '0;
      skid_mode  <= 2'b00;
    end else begin
      state_q    <= state_d;
      // Registered ready: computed from the next state, never from out_ready directly.
      in_ready_q <= (state_d != TWO);
      if (ld_main) begin
        main_dat  <= main_from_skid ? skid_dat  : ext_dat;
        main_mode <= main_from_skid ? skid_mode : in_mode;
      end
      if (ld_skid) begin
        skid_dat  <= ext_dat;
        skid_mode <= in_mode;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
`else
  logic vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= 1'b0;
      main_dat  <= '0;
      main_mode <= 2'b00;
    end else begin
      if (in_xfer) begin
        vld_q     <= 1'b1;
        main_dat  <= ext_dat;
        main_mode <= in_mode;
      end else if (out_xfer) begin
        vld_q <= 1'b0;
      end
    end
  end

  // Single stage: a new word may enter in the same cycle the held one leaves.
  assign in_ready  = !vld_q || out_ready;
  assign out_valid = vld_q;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: self-checking bench for imm_ext_pipe (DI_W=16, DO_W=32).
// Directed vector table for the extension modes, hand sequences for backpressure and reset,
// and a negedge scoreboard/stability monitor that follows every transfer.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic [1:0]  in_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  int tests = 0;
  int fails = 0;
  int pushed = 0;
  int popped = 0;

  logic [33:0] sb[$];
  logic        stall_q = 1'b0;
  logic [33:0] stall_val = '0;

  imm_ext_pipe #(.DI_W(16), .DO_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode)
  );

  always #5 clk = ~clk;

  // Reference extension written arithmetically rather than by bit concatenation.
  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
    logic signed [31:0] s;
    s = $signed(d);
    case (m)
      2'b00:   return {16'h0000, d};
      2'b01:   return s;
      2'b10:   return {d, 16'h0000};
      default: return s * 4;
    endcase
  endfunction

  task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [33:0] exp;
    if (rst) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q && out_valid)
        check("stall_stable", {out_mode, out_data}, stall_val);
      stall_q   = out_valid && !out_ready;
      stall_val = {out_mode, out_data};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got word %h, expected none", {out_mode, out_data});
        end else begin
          exp = sb.pop_front();
          check("sb_order", {out_mode, out_data}, exp);
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_mode, ref_ext(in_data, in_mode)});
        pushed++;
      end
    end
  end

  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic [31:0] e;
  } vec_t;

  initial begin
    vec_t        vt[10];
    logic [15:0] bp_d[3];
    logic [1:0]  bp_m[3];
    int          idx;
    logic        acc;
    int          p0;
    int          q0;

    vt[0] = '{16'h8001, 2'b00, 32'h00008001};
    vt[1] = '{16'h8001, 2'b01, 32'hFFFF8001};
    vt[2] = '{16'h8001, 2'b10, 32'h80010000};
    vt[3] = '{16'h8001, 2'b11, 32'hFFFE0004};
    vt[4] = '{16'h7FFF, 2'b01, 32'h00007FFF};
    vt[5] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
    vt[6] = '{16'h0000, 2'b00, 32'h00000000};
    vt[7] = '{16'h0000, 2'b01, 32'h00000000};
    vt[8] = '{16'h0000, 2'b10, 32'h00000000};
    vt[9] = '{16'h0000, 2'b11, 32'h00000000};
    bp_d[0] = 16'h1111; bp_m[0] = 2'b01;
    bp_d[1] = 16'h8222; bp_m[1] = 2'b11;
    bp_d[2] = 16'h0333; bp_m[2] = 2'b10;

    // Reset state
    #7;
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_out_data",  34'(out_data),  34'd0);
    check("rst_out_mode",  34'(out_mode),  34'd0);
    check("rst_in_ready",  34'(in_ready),  34'd1);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    // Mode table: one word per cycle, each checked one cycle after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = vt[i].d;
      in_mode  = vt[i].m;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("vec_valid", 34'(out_valid), 34'd1);
      check("vec_data",  34'(out_data),  34'(vt[i].e));
      check("vec_mode",  34'(out_mode),  34'(vt[i].m));
    end
    @(posedge clk); #1;
    check("vec_drained", 34'(out_valid), 34'd0);

    // Backpressure: offer A, B, C back to back with out_ready low.
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = bp_d[idx];
      in_mode  = bp_m[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
`ifdef IMM_EXT_SKID_EN
    check("bp_accepted", 34'(idx), 34'd2);
`else
    check("bp_accepted", 34'(idx), 34'd1);
`endif
    check("bp_in_ready", 34'(in_ready), 34'd0);
    check("bp_held_data", {out_mode, out_data}, {bp_m[0], ref_ext(bp_d[0], bp_m[0])});
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin
        in_data = bp_d[idx];
        in_mode = bp_m[idx];
      end
      @(negedge clk);
      check("bp_nogap", 34'(out_valid), 34'd1);
`ifdef IMM_EXT_SKID_EN
      check("bp_ready_reg", 34'(in_ready), (c == 0) ? 34'd0 : 34'd1);
`endif
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_in", 34'(idx), 34'd3);
    check("bp_done", 34'(out_valid), 34'd0);

    // Streaming: 64 random words, both sides always ready.
    p0 = pushed;
    q0 = popped;
    for (int c = 0; c < 64; c++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_mode  = 2'($urandom_range(0, 3));
      @(negedge clk);
      check("stream_in_ready", 34'(in_ready), 34'd1);
      if (c > 0) check("stream_out_valid", 34'(out_valid), 34'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_pushed", 34'(pushed - p0), 34'd64);
    check("stream_popped", 34'(popped - q0), 34'd64);

    // Random stalls on both sides, 1000 words.
    p0 = pushed;
    for (int c = 0; c < 20000 && (pushed - p0) < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("rand_sent", 34'(pushed - p0), 34'd1000);
    check("rand_sb_empty", 34'(sb.size()), 34'd0);
    check("rand_drained", 34'(out_valid), 34'd0);

    // Reset in the middle of a backpressured burst.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hAAAA;
    in_mode   = 2'b01;
    @(posedge clk); #1;
    in_data   = 16'h5555;
    @(posedge clk); #1;
    in_valid  = 1'b0;
`ifdef IMM_EXT_SKID_EN
    check("pre_rst_full", 34'(in_ready), 34'd0);
`endif
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 34'(out_valid), 34'd0);
    check("arst_out_data",  34'(out_data),  34'd0);
    check("arst_out_mode",  34'(out_mode),  34'd0);
    check("arst_in_ready",  34'(in_ready),  34'd1);
    @(negedge clk);
    @(posedge clk); #3;
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    in_mode   = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_rst_valid", 34'(out_valid), 34'd1);
    check("post_rst_data",  34'(out_data),  34'h000001234);
    check("post_rst_mode",  34'(out_mode),  34'd0);
    @(posedge clk); #1;
    check("post_rst_no_stale", 34'(out_valid), 34'd0);
    check("post_rst_sb_empty", 34'(sb.size()), 34'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
